// File: rtl/bpu_gshare_ras_pkg.sv
// Shared definitions for the gshare/BTB/RAS pre-decode predictor.
// Kind encodings, opcode constants, FSM states, counter helper.
package bpu_gshare_ras_pkg;

  typedef enum logic [2:0] {
    K_NONE = 3'd0,
    K_JUMP = 3'd1,
    K_COND = 3'd2,
    K_IND  = 3'd3,
    K_RET  = 3'd4
  } kind_e;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam logic [5:0] OP_JIRL = 6'h13;
  localparam logic [5:0] OP_B    = 6'h14;
  localparam logic [5:0] OP_BL   = 6'h15;
  localparam logic [5:0] OP_BEQ  = 6'h16;
  localparam logic [5:0] OP_BGEU = 6'h1b;

  function automatic logic [1:0] sat_update(
    input logic [1:0] cnt,
    input logic       up
  );
    logic [1:0] res;
    res = cnt;
    if (up) begin
      if (cnt != 2'b11) res = cnt + 2'd1;
    end else begin
      if (cnt != 2'b00) res = cnt - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bpu_gshare_ras_btb_fa.sv
// Fully-associative BTB: combinational lookup, in-place update,
// fill of the lowest free entry, then round-robin replacement.
module bpu_btb_fa
  import bpu_gshare_ras_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             hit,
  output logic [31:0]      hit_target,
  input  logic             wr_en,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_target
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag [ENTRIES];
  logic [31:0]        tgt [ENTRIES];
  logic [IDX_W-1:0]   rr;

  logic             wr_hit;
  logic [IDX_W-1:0] wr_hit_idx;
  logic             free;
  logic [IDX_W-1:0] free_idx;
  logic [IDX_W-1:0] sel;

  always_comb begin
    hit        = 1'b0;
    hit_target = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid[i] && tag[i] == lk_tag) begin
        hit        = 1'b1;
        hit_target = tgt[i];
      end
    end
  end

  // Descending scan so the lowest free index wins.
  always_comb begin
    wr_hit     = 1'b0;
    wr_hit_idx = '0;
    free       = 1'b0;
    free_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid[i] && tag[i] == wr_tag) begin
        wr_hit     = 1'b1;
        wr_hit_idx = IDX_W'(i);
      end
      if (!valid[i]) begin
        free     = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
    sel = wr_hit ? wr_hit_idx : (free ? free_idx : rr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      rr    <= '0;
    end else if (wr_en) begin
      valid[sel] <= 1'b1;
      if (!wr_hit && !free) rr <= rr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag[sel] <= wr_tag;
      tgt[sel] <= wr_target;
    end
  end

endmodule

// File: rtl/bpu_gshare_ras.sv
// Pre-decode branch predictor: gshare direction, FA BTB for jirl,
// return-address stack, speculative history with mispredict repair.
module bpu_gshare_ras
  import bpu_gshare_ras_pkg::*;
#(
  parameter int BTB_ENTRIES = 16,
  parameter int TAG_W       = 30,
  parameter int PHT_IDX_W   = 10,
  parameter int GHR_W       = 8,
  parameter int RAS_DEPTH   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         ready,
  input  logic                         lk_valid,
  input  logic [31:0]                  lk_pc,
  input  logic [31:0]                  lk_inst,
  output logic                         pred_valid,
  output logic [2:0]                   pred_kind,
  output logic                         pred_taken,
  output logic [31:0]                  pred_target,
  output logic                         pred_btb_miss,
  output logic [GHR_W-1:0]             pred_ghr,
  output logic [$clog2(RAS_DEPTH)-1:0] pred_ras_ptr,
  input  logic                         upd_valid,
  input  logic [31:0]                  upd_pc,
  input  logic [2:0]                   upd_kind,
  input  logic                         upd_taken,
  input  logic [31:0]                  upd_target,
  input  logic                         upd_mispredict,
  input  logic [GHR_W-1:0]             upd_ghr,
  input  logic [$clog2(RAS_DEPTH)-1:0] upd_ras_ptr
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int PHT_N = 1 << PHT_IDX_W;

  state_e               state;
  state_e               state_nx;
  logic [PHT_IDX_W-1:0] init_idx;
  logic [PHT_IDX_W-1:0] init_idx_nx;
  logic                 init_we;

  logic [1:0]           pht [PHT_N];
  logic [GHR_W-1:0]     ghr;
  logic [31:0]          ras [RAS_DEPTH];
  logic [PTR_W-1:0]     ras_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_INIT;
      init_idx <= '0;
    end else begin
      state    <= state_nx;
      init_idx <= init_idx_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    init_idx_nx = init_idx;
    init_we     = 1'b0;
    unique case (state)
      S_INIT: begin
        init_we     = 1'b1;
        init_idx_nx = init_idx + 1'b1;
        if (&init_idx) state_nx = S_RUN;
      end
      S_RUN: ;
      default: ;
    endcase
  end

  assign ready      = (state == S_RUN);
  assign pred_valid = lk_valid & ready;

  logic [5:0] op;
  logic [4:0] rd;
  logic [4:0] rj;
  kind_e      kind;
  logic       is_call;

  assign op = lk_inst[31:26];
  assign rd = lk_inst[4:0];
  assign rj = lk_inst[9:5];

  always_comb begin
    kind    = K_NONE;
    is_call = 1'b0;
    unique case (1'b1)
      (op == OP_B || op == OP_BL):
        kind = K_JUMP;
      (op >= OP_BEQ && op <= OP_BGEU):
        kind = K_COND;
      (op == OP_JIRL):
        kind = (rd == 5'd0 && rj == 5'd1) ? K_RET : K_IND;
      default: ;
    endcase
    is_call = (op == OP_BL) || (op == OP_JIRL && rd == 5'd1);
  end

  logic [PHT_IDX_W-1:0] lk_idx;
  logic [1:0]           lk_cnt;
  logic [31:0]          off_j;
  logic [31:0]          off_c;
  logic                 btb_hit;
  logic [31:0]          btb_target;
  logic                 taken_raw;
  logic [31:0]          target_raw;

  assign lk_idx = lk_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(ghr);
  assign lk_cnt = pht[lk_idx];
  assign off_j  = {{4{lk_inst[9]}}, lk_inst[9:0],
                   lk_inst[25:10], 2'b00};
  assign off_c  = {{14{lk_inst[25]}}, lk_inst[25:10], 2'b00};

  always_comb begin
    taken_raw  = 1'b0;
    target_raw = '0;
    unique case (kind)
      K_JUMP: begin
        taken_raw  = 1'b1;
        target_raw = lk_pc + off_j;
      end
      K_COND: begin
        taken_raw  = lk_cnt[1];
        target_raw = lk_pc + off_c;
      end
      K_IND: begin
        taken_raw  = btb_hit;
        target_raw = btb_target;
      end
      K_RET: begin
        taken_raw  = 1'b1;
        target_raw = ras[ras_ptr - 1'b1];
      end
      default: ;
    endcase
  end

  assign pred_kind     = pred_valid ? kind : K_NONE;
  assign pred_taken    = pred_valid & taken_raw;
  assign pred_target   = (pred_valid & taken_raw) ? target_raw : '0;
  assign pred_btb_miss = pred_valid & (kind == K_IND) & ~btb_hit;
  assign pred_ghr      = pred_valid ? ghr : '0;
  assign pred_ras_ptr  = pred_valid ? ras_ptr : '0;

  logic                 upd_go;
  logic                 mp;
  logic [PHT_IDX_W-1:0] upd_idx;
  logic                 pht_we;
  logic [PHT_IDX_W-1:0] pht_widx;
  logic [1:0]           pht_wdata;

  assign upd_go  = upd_valid & ready;
  assign mp      = upd_go & upd_mispredict;
  assign upd_idx = upd_pc[PHT_IDX_W+1:2] ^ PHT_IDX_W'(upd_ghr);

  // Sweep and updates never overlap: updates are dropped until ready.
  always_comb begin
    pht_we    = 1'b0;
    pht_widx  = upd_idx;
    pht_wdata = sat_update(pht[upd_idx], upd_taken);
    if (init_we) begin
      pht_we    = 1'b1;
      pht_widx  = init_idx;
      pht_wdata = 2'b01;
    end else if (upd_go && upd_kind == K_COND) begin
      pht_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (pht_we) pht[pht_widx] <= pht_wdata;
  end

  bpu_btb_fa #(
    .ENTRIES (BTB_ENTRIES),
    .TAG_W   (TAG_W)
  ) u_btb (
    .clk        (clk),
    .rst        (rst),
    .lk_tag     (lk_pc[TAG_W+1:2]),
    .hit        (btb_hit),
    .hit_target (btb_target),
    .wr_en      (upd_go && upd_kind == K_IND && upd_taken),
    .wr_tag     (upd_pc[TAG_W+1:2]),
    .wr_target  (upd_target)
  );

  // Only the kind comes back with a resolved branch, so a direct
  // jump is taken to be bl and re-pushes; a return re-pops.
  logic [PTR_W-1:0] ptr_fix;

  always_comb begin
    ptr_fix = upd_ras_ptr;
    if (upd_kind == K_JUMP) ptr_fix = upd_ras_ptr + 1'b1;
    else if (upd_kind == K_RET) ptr_fix = upd_ras_ptr - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr     <= '0;
      ras_ptr <= '0;
    end else if (mp) begin
      ghr     <= (upd_kind == K_COND) ?
                 {upd_ghr[GHR_W-2:0], upd_taken} : upd_ghr;
      ras_ptr <= ptr_fix;
    end else if (pred_valid) begin
      if (kind == K_COND) ghr <= {ghr[GHR_W-2:0], taken_raw};
      if (is_call) ras_ptr <= ras_ptr + 1'b1;
      else if (kind == K_RET) ras_ptr <= ras_ptr - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (pred_valid && is_call && !mp) ras[ras_ptr] <= lk_pc + 32'd4;
  end

endmodule

// File: tb/tb_bpu_gshare_ras.sv
// Scoreboard bench for bpu_gshare_ras: expected predictions are
// queued as lookups are driven and compared at the next falling edge.
module tb_bpu_gshare_ras;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic        lk_valid;
  logic [31:0] lk_pc;
  logic [31:0] lk_inst;
  logic        pred_valid;
  logic [2:0]  pred_kind;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        pred_btb_miss;
  logic [7:0]  pred_ghr;
  logic [2:0]  pred_ras_ptr;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [2:0]  upd_kind;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic [7:0]  upd_ghr;
  logic [2:0]  upd_ras_ptr;

  always #5 clk = ~clk;

  bpu_gshare_ras dut (
    .clk            (clk),
    .rst            (rst),
    .ready          (ready),
    .lk_valid       (lk_valid),
    .lk_pc          (lk_pc),
    .lk_inst        (lk_inst),
    .pred_valid     (pred_valid),
    .pred_kind      (pred_kind),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .pred_btb_miss  (pred_btb_miss),
    .pred_ghr       (pred_ghr),
    .pred_ras_ptr   (pred_ras_ptr),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_kind       (upd_kind),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_mispredict (upd_mispredict),
    .upd_ghr        (upd_ghr),
    .upd_ras_ptr    (upd_ras_ptr)
  );

  typedef struct packed {
    logic [2:0]  kind;
    logic        taken;
    logic [31:0] tgt;
    logic        miss;
    logic [7:0]  ghr;
    logic [2:0]  rp;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] g = '0;
  logic [2:0] p = '0;

  localparam logic [31:0] I_B40  = {6'h14, 16'h0010, 10'h000};
  localparam logic [31:0] I_BM1  = {6'h14, 16'hffff, 10'h3ff};
  localparam logic [31:0] I_BEQ  = {6'h16, 16'hffff, 10'h000};
  localparam logic [31:0] I_BL   = {6'h15, 26'h0};
  localparam logic [31:0] I_RET  = {6'h13, 16'h0, 5'd1, 5'd0};
  localparam logic [31:0] I_IND  = {6'h13, 16'h0, 5'd12, 5'd0};
  localparam logic [31:0] I_ICAL = {6'h13, 16'h0, 5'd12, 5'd1};

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      check("valid", 64'(pred_valid), 64'd1);
      check("kind", 64'(pred_kind), 64'(e.kind));
      check("taken", 64'(pred_taken), 64'(e.taken));
      check("target", 64'(pred_target), 64'(e.tgt));
      check("btb_miss", 64'(pred_btb_miss), 64'(e.miss));
      check("ghr", 64'(pred_ghr), 64'(e.ghr));
      check("ras_ptr", 64'(pred_ras_ptr), 64'(e.rp));
    end
  end

  task automatic look(input logic [31:0] pc, input logic [31:0] inst,
                      input logic [2:0] kind, input logic taken,
                      input logic [31:0] tgt, input logic miss);
    logic [5:0] op;
    exp_t x;
    op = inst[31:26];
    x = '{kind: kind, taken: taken, tgt: tgt, miss: miss,
          ghr: g, rp: p};
    q.push_back(x);
    lk_valid = 1'b1;
    lk_pc    = pc;
    lk_inst  = inst;
    if (kind == 3'd2) g = {g[6:0], taken};
    if (op == 6'h15 || (op == 6'h13 && inst[4:0] == 5'd1)) p = p + 3'd1;
    else if (kind == 3'd4) p = p - 3'd1;
  endtask

  task automatic upd(input logic [2:0] kind, input logic [31:0] pc,
                     input logic taken, input logic [31:0] tgt,
                     input logic mispred, input logic [7:0] gh,
                     input logic [2:0] rp);
    upd_valid      = 1'b1;
    upd_kind       = kind;
    upd_pc         = pc;
    upd_taken      = taken;
    upd_target     = tgt;
    upd_mispredict = mispred;
    upd_ghr        = gh;
    upd_ras_ptr    = rp;
    if (mispred) begin
      g = (kind == 3'd2) ? {gh[6:0], taken} : gh;
      p = rp + ((kind == 3'd1) ? 3'd1 : 3'd0)
             - ((kind == 3'd4) ? 3'd1 : 3'd0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    lk_valid  = 1'b0;
    upd_valid = 1'b0;
  endtask

  function automatic logic [31:0] bpc(input int i);
    return 32'h1c001000 + 32'(4 * i);
  endfunction

  function automatic logic [31:0] btgt(input int i);
    return 32'h20000000 + 32'(256 * i);
  endfunction

  int n;

  initial begin
    rst = 1'b1;
    lk_valid = 1'b1; lk_pc = 32'h1c000200; lk_inst = I_BL;
    upd_valid = 1'b1; upd_pc = '0; upd_kind = 3'd1; upd_taken = 1'b1;
    upd_target = '0; upd_mispredict = 1'b1; upd_ghr = 8'hff;
    upd_ras_ptr = 3'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_pred_valid", 64'(pred_valid), 64'd0);
    check("rst_kind", 64'(pred_kind), 64'd0);
    check("rst_target", 64'(pred_target), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (100) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n = 0;
    while (!ready && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    check("init_cycles", 64'(n), 64'd1024);
    lk_valid = 1'b0; upd_valid = 1'b0;

    // first cond lookup sees 01; same-cycle update not bypassed
    look(32'h1c000100, I_BEQ, 3'd2, 1'b0, 32'h0, 1'b0);
    upd(3'd2, 32'h1c000100, 1'b1, 32'h0, 1'b0, 8'h00, 3'd0);
    tick();
    look(32'h1c000100, I_BEQ, 3'd2, 1'b1, 32'h1c0000fc, 1'b0);
    tick();
    look(32'h1c000100, I_B40, 3'd1, 1'b1, 32'h1c000140, 1'b0);
    tick();
    look(32'h1c000100, I_BM1, 3'd1, 1'b1, 32'h1c0000fc, 1'b0);
    tick();

    // ceiling: T,T,T,N from 01 leaves 10
    upd(3'd2, 32'h1c000300, 1'b1, 32'h0, 1'b0, 8'h01, 3'd0); tick();
    upd(3'd2, 32'h1c000300, 1'b1, 32'h0, 1'b0, 8'h01, 3'd0); tick();
    upd(3'd2, 32'h1c000300, 1'b1, 32'h0, 1'b0, 8'h01, 3'd0); tick();
    upd(3'd2, 32'h1c000300, 1'b0, 32'h0, 1'b0, 8'h01, 3'd0); tick();
    look(32'h1c000300, I_BEQ, 3'd2, 1'b1, 32'h1c0002fc, 1'b0);
    tick();

    // floor: N,N,T,T from 01 leaves 10
    upd(3'd2, 32'h1c000400, 1'b0, 32'h0, 1'b0, 8'h00, 3'd0); tick();
    upd(3'd2, 32'h1c000400, 1'b0, 32'h0, 1'b0, 8'h00, 3'd0); tick();
    upd(3'd2, 32'h1c000400, 1'b1, 32'h0, 1'b0, 8'h00, 3'd0); tick();
    upd(3'd2, 32'h1c000400, 1'b1, 32'h0, 1'b0, 8'h00, 3'd0); tick();
    look(32'h1c00040c, I_BEQ, 3'd2, 1'b1, 32'h1c000408, 1'b0);
    tick();

    // call / return and ras pointer recovery
    look(32'h1c000200, I_BL, 3'd1, 1'b1, 32'h1c000200, 1'b0); tick();
    look(32'h1c000300, I_RET, 3'd4, 1'b1, 32'h1c000204, 1'b0); tick();
    upd(3'd1, 32'h1c000200, 1'b1, 32'h1c000200, 1'b1, 8'h5a, 3'd0);
    tick();
    look(32'h1c000300, I_RET, 3'd4, 1'b1, 32'h1c000204, 1'b0); tick();

    // mispredict beats same-cycle lookup shift
    look(32'h1c000500, I_BEQ, 3'd2, 1'b0, 32'h0, 1'b0);
    upd(3'd2, 32'h1c000600, 1'b1, 32'h0, 1'b1, 8'h81, 3'd0);
    tick();
    look(32'h1c000100, I_B40, 3'd1, 1'b1, 32'h1c000140, 1'b0); tick();

    // return mispredict and pointer wrap
    upd(3'd4, 32'h1c000600, 1'b1, 32'h0, 1'b1, 8'h10, 3'd0); tick();
    look(32'h1c000700, I_BL, 3'd1, 1'b1, 32'h1c000700, 1'b0); tick();
    look(32'h1c000800, I_RET, 3'd4, 1'b1, 32'h1c000704, 1'b0); tick();
    upd(3'd3, 32'h1c000600, 1'b0, 32'h0, 1'b1, 8'h22, 3'd5); tick();
    look(32'h1c000100, I_B40, 3'd1, 1'b1, 32'h1c000140, 1'b0); tick();

    // BTB miss, indirect call pushes RAS
    look(bpc(0), I_IND, 3'd3, 1'b0, 32'h0, 1'b1); tick();
    look(32'h1c000900, I_ICAL, 3'd3, 1'b0, 32'h0, 1'b1); tick();
    look(32'h1c000a00, I_RET, 3'd4, 1'b1, 32'h1c000904, 1'b0); tick();

    for (int i = 0; i <= 16; i++) begin
      upd(3'd3, bpc(i), 1'b1, btgt(i), 1'b0, 8'h00, 3'd0);
      tick();
    end
    look(bpc(0), I_IND, 3'd3, 1'b0, 32'h0, 1'b1); tick();
    look(bpc(1), I_IND, 3'd3, 1'b1, btgt(1), 1'b0); tick();
    look(bpc(15), I_IND, 3'd3, 1'b1, btgt(15), 1'b0); tick();
    look(bpc(16), I_IND, 3'd3, 1'b1, btgt(16), 1'b0); tick();

    upd(3'd3, bpc(5), 1'b1, 32'h30000000, 1'b0, 8'h00, 3'd0); tick();
    upd(3'd3, bpc(17), 1'b1, btgt(17), 1'b0, 8'h00, 3'd0); tick();
    upd(3'd3, 32'h1c002000, 1'b0, 32'h4000, 1'b0, 8'h00, 3'd0); tick();
    look(bpc(5), I_IND, 3'd3, 1'b1, 32'h30000000, 1'b0); tick();
    look(bpc(1), I_IND, 3'd3, 1'b0, 32'h0, 1'b1); tick();
    look(bpc(2), I_IND, 3'd3, 1'b1, btgt(2), 1'b0); tick();
    look(bpc(17), I_IND, 3'd3, 1'b1, btgt(17), 1'b0); tick();
    look(32'h1c002000, I_IND, 3'd3, 1'b0, 32'h0, 1'b1); tick();

    tick();
    tick();
    check("queue_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
